// File: rtl/flag_context_stack_pkg.sv
// Shared control-unit definitions for the flag context stack: flag word layout
// and the restore FSM state encoding.
package flag_context_stack_pkg;

    localparam int FLAG_W = 5;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_M = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_t;

endpackage

// File: rtl/flag_context_stack_if.sv
// Save/restore handshake between the control-unit sequencer (master) and the
// flag context stack (slave).
interface flag_context_stack_if
    import flag_context_stack_pkg::*;
#(
    parameter int FLAG_W = flag_context_stack_pkg::FLAG_W
);

    logic [FLAG_W-1:0] flags_in;
    logic              push_req;
    logic              pop_req;
    logic              restore_valid;
    logic [FLAG_W-1:0] restore_flags;
    logic              restore_ack;

    modport master (
        output flags_in,
        output push_req,
        output pop_req,
        output restore_ack,
        input  restore_valid,
        input  restore_flags
    );

    modport slave (
        input  flags_in,
        input  push_req,
        input  pop_req,
        input  restore_ack,
        output restore_valid,
        output restore_flags
    );

endinterface

// File: rtl/flag_context_stack_lifo_mem.sv
// Storage array for saved flag contexts: one synchronous write port and one
// asynchronous read port; contents are never reset.
module flag_lifo_mem
    import flag_context_stack_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int FLAG_W = flag_context_stack_pkg::FLAG_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [FLAG_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [FLAG_W-1:0] rd_data
);

    logic [FLAG_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/flag_context_stack.sv
// LIFO save/restore of the processor flag word with a valid/ack restore path.
// Define FLAG_STACK_STATS_EN to add the high_water depth statistic output.
module flag_context_stack
    import flag_context_stack_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int FLAG_W = flag_context_stack_pkg::FLAG_W,
    parameter int DW     = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    flag_context_stack_if.slave  bus,
    output logic [DW-1:0]        depth,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 overflow_err,
`ifdef FLAG_STACK_STATS_EN
    output logic [DW-1:0]        high_water,
`endif
    output logic                 underflow_err
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              restore_valid_q, restore_valid_d;
    logic [FLAG_W-1:0] restore_flags_q, restore_flags_d;
    logic              overflow_err_q, overflow_err_d;
    logic              underflow_err_q, underflow_err_d;
`ifdef FLAG_STACK_STATS_EN
    logic [DW-1:0]     high_water_q, high_water_d;
`endif

    logic              is_full, is_empty;
    logic              mem_we;
    logic [AW-1:0]     rd_addr;
    logic [FLAG_W-1:0] rd_data;

    assign is_full  = (depth_q == DW'(DEPTH));
    assign is_empty = (depth_q == '0);
    assign rd_addr  = AW'(depth_q - DW'(1));

    flag_lifo_mem #(
        .DEPTH  (DEPTH),
        .FLAG_W (FLAG_W),
        .AW     (AW)
    ) u_mem (
        .clock   (clock),
        .we      (mem_we),
        .wr_addr (depth_q[AW-1:0]),
        .wr_data (bus.flags_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            depth_q         <= '0;
            restore_valid_q <= 1'b0;
            restore_flags_q <= '0;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
`ifdef FLAG_STACK_STATS_EN
            high_water_q    <= '0;
`endif
        end else begin
            state_q         <= state_d;
            depth_q         <= depth_d;
            restore_valid_q <= restore_valid_d;
            restore_flags_q <= restore_flags_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
`ifdef FLAG_STACK_STATS_EN
            high_water_q    <= high_water_d;
`endif
        end
    end

    // A pop only leaves IDLE when there is something to hand back; a push+pop
    // pair always does, since the live flags are forwarded directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.pop_req && (bus.push_req || !is_empty)) begin
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                if (bus.restore_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        depth_d         = depth_q;
        restore_valid_d = restore_valid_q;
        restore_flags_d = restore_flags_q;
        overflow_err_d  = overflow_err_q;
        underflow_err_d = underflow_err_q;
        mem_we          = 1'b0;
        if (state_q == IDLE) begin
            if (bus.push_req && bus.pop_req) begin
                restore_flags_d = bus.flags_in;
                restore_valid_d = 1'b1;
            end else if (bus.push_req) begin
                if (is_full) begin
                    overflow_err_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    depth_d = depth_q + DW'(1);
                end
            end else if (bus.pop_req) begin
                if (is_empty) begin
                    underflow_err_d = 1'b1;
                end else begin
                    restore_flags_d = rd_data;
                    restore_valid_d = 1'b1;
                    depth_d         = depth_q - DW'(1);
                end
            end
        end else if (bus.restore_ack) begin
            restore_valid_d = 1'b0;
        end
    end

`ifdef FLAG_STACK_STATS_EN
    // Depth only grows through pushes, so tracking the next depth is enough.
    always_comb begin
        high_water_d = high_water_q;
        if (depth_d > high_water_q) begin
            high_water_d = depth_d;
        end
    end

    assign high_water = high_water_q;
`endif

    always_comb begin
        busy  = (state_q == RESTORE);
        full  = is_full;
        empty = is_empty;
    end

    assign depth             = depth_q;
    assign overflow_err      = overflow_err_q;
    assign underflow_err     = underflow_err_q;
    assign bus.restore_valid = restore_valid_q;
    assign bus.restore_flags = restore_flags_q;

endmodule

// File: tb/tb_flag_context_stack.sv
// Scoreboard bench for flag_context_stack: expected restore words are queued by
// the stimulus and checked by a monitor at each accepted restore handshake.
module tb_flag_context_stack;
    import flag_context_stack_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] depth;
    logic          full, empty, busy, overflow_err, underflow_err;
`ifdef FLAG_STACK_STATS_EN
    logic [DW-1:0] high_water;
`endif

    flag_context_stack_if #(.FLAG_W(FLAG_W)) bus_if ();

    flag_context_stack #(.DEPTH(DEPTH), .FLAG_W(FLAG_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus_if),
        .depth         (depth),
        .full          (full),
        .empty         (empty),
        .busy          (busy),
        .overflow_err  (overflow_err),
`ifdef FLAG_STACK_STATS_EN
        .high_water    (high_water),
`endif
        .underflow_err (underflow_err)
    );

    always #5 clock = ~clock;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [FLAG_W-1:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every accepted restore must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && bus_if.restore_valid && bus_if.restore_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_restore", 32'(bus_if.restore_flags), 32'hFFFF_FFFF);
            end else begin
                check("restore_flags", 32'(bus_if.restore_flags), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic apply_stimulus(input bit push, input bit pop, input logic [FLAG_W-1:0] v);
        bus_if.flags_in = v;
        bus_if.push_req = push;
        bus_if.pop_req  = pop;
        tick();
        bus_if.push_req = 1'b0;
        bus_if.pop_req  = 1'b0;
    endtask

    task automatic check_output(input int exp_depth, input bit exp_full, input bit exp_empty,
                                input bit exp_ovf, input bit exp_unf);
        check("depth", 32'(depth), 32'(exp_depth));
        check("full", 32'(full), 32'(exp_full));
        check("empty", 32'(empty), 32'(exp_empty));
        check("overflow_err", 32'(overflow_err), 32'(exp_ovf));
        check("underflow_err", 32'(underflow_err), 32'(exp_unf));
    endtask

    // Issues a pop (or push+pop bypass), then acknowledges the returned word.
    task automatic restore(input bit push, input logic [FLAG_W-1:0] v,
                           input logic [FLAG_W-1:0] exp_flags, input int exp_depth);
        sb.push_back(exp_flags);
        apply_stimulus(push, 1'b1, v);
        check("valid_after_pop", 32'(bus_if.restore_valid), 32'd1);
        check("busy_after_pop", 32'(busy), 32'd1);
        check("depth_after_pop", 32'(depth), 32'(exp_depth));
        bus_if.restore_ack = 1'b1;
        tick();
        bus_if.restore_ack = 1'b0;
        check("valid_after_ack", 32'(bus_if.restore_valid), 32'd0);
        check("busy_after_ack", 32'(busy), 32'd0);
    endtask

    initial begin
        bus_if.flags_in    = '0;
        bus_if.push_req    = 1'b0;
        bus_if.pop_req     = 1'b0;
        bus_if.restore_ack = 1'b0;

        apply_reset(2);
        check_output(0, 0, 1, 0, 0);
        check("valid_reset", 32'(bus_if.restore_valid), 32'd0);
        check("busy_reset", 32'(busy), 32'd0);
`ifdef FLAG_STACK_STATS_EN
        check("high_water_reset", 32'(high_water), 32'd0);
`endif

        // LIFO order
        apply_stimulus(1, 0, 5'h11);
        apply_stimulus(1, 0, 5'h0A);
        apply_stimulus(1, 0, 5'h1F);
        check_output(3, 0, 0, 0, 0);
`ifdef FLAG_STACK_STATS_EN
        check("high_water_3", 32'(high_water), 32'd3);
`endif
        restore(0, '0, 5'h1F, 2);
        restore(0, '0, 5'h0A, 1);
        restore(0, '0, 5'h11, 0);
        check_output(0, 0, 1, 0, 0);

        // Held handshake with pushes attempted while busy
        apply_stimulus(1, 0, 5'h07);
        apply_stimulus(1, 0, 5'h09);
        sb.push_back(5'h09);
        apply_stimulus(0, 1, '0);
        bus_if.flags_in = 5'h1E;
        bus_if.push_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", 32'(bus_if.restore_valid), 32'd1);
            check("hold_flags", 32'(bus_if.restore_flags), 32'h09);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_depth", 32'(depth), 32'd1);
            tick();
        end
        bus_if.push_req    = 1'b0;
        bus_if.restore_ack = 1'b1;
        tick();
        bus_if.restore_ack = 1'b0;
        check("hold_valid_after_ack", 32'(bus_if.restore_valid), 32'd0);
        check_output(1, 0, 0, 0, 0);
        restore(0, '0, 5'h07, 0);

        // Fill to DEPTH, bypass while full, then overflow
        for (int i = 1; i <= DEPTH; i++) begin
            apply_stimulus(1, 0, FLAG_W'(i));
        end
        check_output(DEPTH, 1, 0, 0, 0);
        restore(1, 5'h15, 5'h15, DEPTH);
        check_output(DEPTH, 1, 0, 0, 0);
        apply_stimulus(1, 0, 5'h1D);
        check_output(DEPTH, 1, 0, 1, 0);
`ifdef FLAG_STACK_STATS_EN
        check("high_water_full", 32'(high_water), 32'(DEPTH));
`endif
        for (int i = DEPTH; i >= 1; i--) begin
            restore(0, '0, FLAG_W'(i), i - 1);
        end
        check_output(0, 0, 1, 1, 0);
        apply_stimulus(0, 1, '0);
        check("underflow_valid", 32'(bus_if.restore_valid), 32'd0);
        check("underflow_busy", 32'(busy), 32'd0);
        tick();
        check("underflow_valid_later", 32'(bus_if.restore_valid), 32'd0);
        check_output(0, 0, 1, 1, 1);

        // Bypass at depth 2 and at empty
        apply_reset(1);
        check_output(0, 0, 1, 0, 0);
        apply_stimulus(1, 0, 5'h01);
        apply_stimulus(1, 0, 5'h02);
        restore(1, 5'h05, 5'h05, 2);
        restore(0, '0, 5'h02, 1);
        restore(0, '0, 5'h01, 0);
        restore(1, 5'h1C, 5'h1C, 0);
        check_output(0, 0, 1, 0, 0);

        // Reset while a restore is pending
        apply_stimulus(1, 0, 5'h0C);
        apply_stimulus(1, 0, 5'h0D);
        apply_stimulus(1, 0, 5'h0E);
        apply_stimulus(0, 1, '0);
        check("pending_valid", 32'(bus_if.restore_valid), 32'd1);
        check("pending_flags", 32'(bus_if.restore_flags), 32'h0E);
        apply_reset(1);
        check("reset_mid_valid", 32'(bus_if.restore_valid), 32'd0);
        check("reset_mid_busy", 32'(busy), 32'd0);
        check_output(0, 0, 1, 0, 0);
`ifdef FLAG_STACK_STATS_EN
        check("high_water_after_reset", 32'(high_water), 32'd0);
        apply_stimulus(1, 0, 5'h11);
        apply_stimulus(1, 0, 5'h0A);
        apply_stimulus(1, 0, 5'h1F);
        check("high_water_again", 32'(high_water), 32'd3);
`endif

        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_context_stack.md
Name: flag_context_stack

Overview:
- LIFO save/restore unit for the 5-bit processor flag word {N,Z,C,V,M}, as presented by the special flag register.
- On exception/SWI entry, the control unit pushes the current flags.
- On return, the control unit pops a saved word, which is offered back to the flag register through a valid/ack restore handshake.
- The block sits between the control unit sequencer and the flag register. It consumes the flag outputs and returns restore data.

Parameters:
- DEPTH, 8, number of saved flag contexts (power of two, ≥2).
- FLAG_W, 5, flag word width; bit order {negative, zero, carry, overflow, mode}, MSB first.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flags_in  input  FLAG_W  live flag word from the flag register, sampled at posedge.
- push_req  input  1  save flags_in (single-cycle pulse or level; one push per accepted cycle).
- pop_req  input  1  request restore of the most recent saved context.
- restore_valid  output  1  restore_flags holds a context awaiting acceptance.
- restore_flags  output  FLAG_W  context being restored.
- restore_ack  input  1  flag register accepted restore_flags.
- depth  output  $clog2(DEPTH+1)  number of stored contexts.
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- busy  output  1  FSM in RESTORE; push/pop ignored.
- overflow_err  output  1  sticky: push attempted while full.
- underflow_err  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (synchronous, high): FSM=IDLE; depth=0; restore_valid=0; restore_flags=0; overflow_err=0; underflow_err=0; busy=0; empty=1; full=0. Storage contents are don't-care. Reset overrides all other inputs, including mid-RESTORE, where restore_valid drops the following edge with no restore delivered.
- FSM has two states: IDLE and RESTORE.
- IDLE, push_req=1, pop_req=0:
  - Not full: mem[depth] <= flags_in; depth+1.
  - Full: no write, depth unchanged, overflow_err <= 1.
- IDLE, pop_req=1, push_req=0:
  - Not empty: restore_flags <= mem[depth-1]; depth-1; restore_valid <= 1; go to RESTORE.
  - Empty: underflow_err <= 1; stay in IDLE; no valid.
- IDLE, push_req=1, pop_req=1: bypass.
  - restore_flags <= flags_in; depth unchanged; no storage write; no error even if full or empty.
  - restore_valid <= 1; go to RESTORE.
- Pop latency: pop_req sampled at edge k gives restore_valid=1 and stable data after edge k.
- RESTORE:
  - restore_valid and restore_flags are held stable until restore_ack is sampled high.
  - On that edge: restore_valid <= 0; go to IDLE.
  - restore_ack in IDLE is ignored.
- RESTORE: push_req and pop_req are ignored; no error flags are set. The sequencer must wait while busy=1.
- Error flags are sticky until reset and have no effect on stack operation.
- full/empty/depth are registered state. They reflect all pushes and pops completed at prior edges.
- Back-to-back: a push in the cycle after ack is accepted normally. Minimum pop-to-pop spacing is 2 cycles (pop, ack).

Optional Feature:
- Macro: FLAG_STACK_STATS_EN.
- Defined: adds output high_water [$clog2(DEPTH+1)-1:0].
  - Reset to 0.
  - Updated to the new depth whenever a push makes depth exceed the current value.
  - Never decreases except on reset.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared control-unit package holds:
  - Flag bit index constants (FLAG_N=4, FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_M=0).
  - FLAG_W.
  - FSM state typedef {IDLE, RESTORE}.
- One natural sub-module: flag_lifo_mem, the DEPTH x FLAG_W register array with write port (addr, data, we) and read port (addr). No reset on contents.
- Pointer, FSM and error logic stay in the top module.

Test Plan:
- Reset: assert reset 2 cycles → depth=0, empty=1, full=0, restore_valid=0, both error flags 0.
- LIFO order: push 5'h11, 5'h0A, 5'h1F; then pop and ack each → restored 5'h1F, 5'h0A, 5'h11. depth goes 3,2,1,0. restore_valid rises 1 edge after each pop.
- Handshake hold: pop with restore_ack held low 4 cycles → valid and data stable, busy=1. push_req during the wait is ignored (depth unchanged). Ack → valid=0 the next edge.
- Boundaries, DEPTH=8:
  - 9 pushes → full=1, depth=8, overflow_err=1.
  - 8 pops/acks, then a 9th pop → underflow_err=1, restore_valid stays 0.
- Simultaneous push+pop: depth=2, flags_in=5'h05 → restore_flags=5'h05, depth stays 2, no write. Repeat while full → no overflow_err.
- Reset mid-RESTORE: pop then reset before ack → restore_valid=0, depth=0 next edge. With FLAG_STACK_STATS_EN, high_water=0 after reset and 3 after the 3-push scenario.
